// File: rtl/libv_pkg.sv
// Shared libv helpers: width arithmetic used to size pointers and counters.
package libv_pkg;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ceil(log2(n)), never below 1 so a 1-entry range still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return max(r, 1);
  endfunction

endpackage

// File: rtl/libv_fifo_mem.sv
// W x N register array: one synchronous write port, one asynchronous read port.
module libv_fifo_mem #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/libv_fifo.sv
// Single-clock FIFO with valid/accept handshakes; depth need not be a power of two.
module libv_fifo
  import libv_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic [W-1:0]            in_data,
  output logic                    in_accept,
  output logic                    out_vld,
  output logic [W-1:0]            out_data,
  input  logic                    out_accept,
  output logic [clog2(N+1)-1:0]   count_r,
  output logic                    empty_r,
  output logic                    full_r
);

  localparam int PW = clog2(N);
  localparam int CW = clog2(N + 1);

  if (N < 2 || W < 1) begin : g_param_check
    $error("libv_fifo: requires N >= 2 and W >= 1");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [CW-1:0] count_nxt;

  assign in_accept = ~full_r;
  assign out_vld   = ~empty_r;
  assign push      = in_vld & ~full_r;
  assign pop       = ~empty_r & out_accept;

  // Flags follow the next occupancy so they stay correct when the pointers coincide.
  always_comb begin
    count_nxt = count_r;
    if (push && !pop) count_nxt = count_r + CW'(1);
    if (pop && !push) count_nxt = count_r - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(N - 1)) ? '0 : rd_ptr + PW'(1);
      count_r <= count_nxt;
      empty_r <= (count_nxt == '0);
      full_r  <= (count_nxt == CW'(N));
    end
  end

  libv_fifo_mem #(
    .W  (W),
    .N  (N),
    .AW (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_libv_fifo.sv
// Directed bench for libv_fifo: N=4 and N=3 instances, hand-computed expectations.
module tb_libv_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=4 instance
  logic       vld4 = 1'b0, acc4 = 1'b0;
  logic [7:0] din4 = '0, od4;
  logic       ia4, ov4, e4, f4;
  logic [2:0] cnt4;

  // N=3 instance
  logic       vld3 = 1'b0, acc3 = 1'b0;
  logic [7:0] din3 = '0, od3;
  logic       ia3, ov3, e3, f3;
  logic [1:0] cnt3;

  int checks = 0;
  int failures = 0;

  libv_fifo #(.W(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_vld(vld4), .in_data(din4), .in_accept(ia4),
    .out_vld(ov4), .out_data(od4), .out_accept(acc4),
    .count_r(cnt4), .empty_r(e4), .full_r(f4)
  );

  libv_fifo #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_vld(vld3), .in_data(din3), .in_accept(ia3),
    .out_vld(ov3), .out_data(od3), .out_accept(acc3),
    .count_r(cnt3), .empty_r(e3), .full_r(f3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nin, nexp, cyc;

    // reset, then idle with out_accept high
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    acc4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle_out_vld", 32'(ov4), 0);
      check("idle_in_accept", 32'(ia4), 1);
      check("idle_count", 32'(cnt4), 0);
      check("idle_empty", 32'(e4), 1);
      tick();
    end
    check("idle3_count", 32'(cnt3), 0);

    // fill N=4, stall fifth push, then drain five
    acc4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld4 = 1'b1;
      din4 = 8'hA0 + 8'(i);
      check("fill_in_accept", 32'(ia4), 1);
      tick();
      check("fill_count", 32'(cnt4), 32'(i + 1));
    end
    din4 = 8'hA4;
    check("full_flag", 32'(f4), 1);
    check("full_count", 32'(cnt4), 4);
    check("full_in_accept", 32'(ia4), 0);
    tick(); tick();
    check("stall_count", 32'(cnt4), 4);
    acc4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_out_vld", 32'(ov4), 1);
      check("drain_data", 32'(od4), 32'(8'hA0 + 8'(k)));
      if (k == 0) check("drain_in_accept_full", 32'(ia4), 0);
      if (k == 1) check("drain_in_accept_freed", 32'(ia4), 1);
      tick();
      if (k == 1) vld4 = 1'b0;
    end
    check("drain_empty", 32'(e4), 1);
    check("drain_out_vld_low", 32'(ov4), 0);

    // count 2, simultaneous push and pop
    acc4 = 1'b0;
    vld4 = 1'b1; din4 = 8'h10; tick();
    din4 = 8'h20; tick();
    check("sim_pre_count", 32'(cnt4), 2);
    din4 = 8'h55; acc4 = 1'b1;
    check("sim_head0", 32'(od4), 32'h10);
    tick();
    vld4 = 1'b0;
    check("sim_count", 32'(cnt4), 2);
    check("sim_head1", 32'(od4), 32'h20);
    tick();
    check("sim_tail", 32'(od4), 32'h55);
    check("sim_tail_count", 32'(cnt4), 1);
    tick();
    check("sim_empty", 32'(e4), 1);

    // reset mid-operation with push and pop requested
    acc4 = 1'b0;
    vld4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din4 = 8'h31 + 8'(i);
      tick();
    end
    check("rst_pre_count", 32'(cnt4), 3);
    rst = 1'b1; din4 = 8'h99; acc4 = 1'b1;
    tick();
    rst = 1'b0; vld4 = 1'b0;
    check("rst_count", 32'(cnt4), 0);
    check("rst_out_vld", 32'(ov4), 0);
    check("rst_in_accept", 32'(ia4), 1);
    vld4 = 1'b1; din4 = 8'h77;
    tick();
    vld4 = 1'b0;
    check("rst_post_vld", 32'(ov4), 1);
    check("rst_post_data", 32'(od4), 32'h77);
    check("rst_post_count", 32'(cnt4), 1);
    tick();
    check("rst_post_empty", 32'(e4), 1);

    // latency: push into empty FIFO is not visible the same cycle
    acc4 = 1'b0;
    vld4 = 1'b1; din4 = 8'h11;
    check("lat_same_cycle", 32'(ov4), 0);
    tick();
    vld4 = 1'b0;
    check("lat_next_vld", 32'(ov4), 1);
    check("lat_next_data", 32'(od4), 32'h11);

    // N=3: 20 items through with random consumer
    nin = 0; nexp = 0; cyc = 0;
    while (nexp < 20 && cyc < 400) begin
      acc3 = 1'($urandom_range(0, 1));
      vld3 = (nin < 20);
      din3 = 8'(nin);
      check("n3_count_model", 32'(cnt3), 32'(nin - nexp));
      check("n3_count_bound", 32'(cnt3 <= 2'd3), 1);
      check("n3_vld_model", 32'(ov3), 32'(nin != nexp));
      if (ov3 && acc3) check("n3_data", 32'(od3), 32'(nexp));
      if (vld3 && ia3) nin++;
      if (ov3 && acc3) nexp++;
      tick();
      cyc++;
    end
    vld3 = 1'b0;
    check("n3_all_out", 32'(nexp), 20);
    check("n3_final_empty", 32'(e3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
